// File: rtl/l1_block_fill_ctrl.sv
// L1 line-fill / writeback sequencer between the L1 data SRAM wrapper and the memory bus.
// Define L1_FILL_CRITICAL_WORD_FIRST_EN to start the fill at req_word instead of word 0.
module l1_block_fill_ctrl #(
    parameter int N_SET_BITS   = 6,
    parameter int N_FRAME_BITS = 1,
    parameter int BLOCK_SIZE   = 2,
    parameter int N_BLOCK_BITS = 1
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wb,
    input  logic [N_SET_BITS-1:0]    req_set,
    input  logic [N_FRAME_BITS-1:0]  req_frame,
    input  logic [N_BLOCK_BITS-1:0]  req_word,
    input  logic [31:0]              req_fill_addr,
    input  logic [31:0]              req_wb_addr,
    output logic                     done,
    output logic [31:0]              bus_addr,
    output logic                     bus_ren,
    output logic                     bus_wen,
    output logic [31:0]              bus_wdata,
    input  logic [31:0]              bus_rdata,
    input  logic                     bus_busy,
    output logic [N_SET_BITS-1:0]    sram_set,
    output logic [N_FRAME_BITS-1:0]  sram_frame,
    output logic                     sram_cs,
    output logic                     sram_we,
    output logic                     sram_oe,
    output logic [N_BLOCK_BITS-1:0]  sram_word,
    output logic [31:0]              sram_wdata,
    input  logic [BLOCK_SIZE*32-1:0] sram_rdata,
    input  logic                     sram_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_RD,
        S_WB_REQ,
        S_FILL_REQ,
        S_FILL_WR,
        S_DONE
    } state_e;

    localparam logic [N_BLOCK_BITS-1:0] LP_LAST = N_BLOCK_BITS'(BLOCK_SIZE - 1);

    state_e                    r_state;
    state_e                    w_next_state;
    logic [N_BLOCK_BITS-1:0]   r_cnt;
    logic [N_BLOCK_BITS-1:0]   r_start;
    logic [N_SET_BITS-1:0]     r_set;
    logic [N_FRAME_BITS-1:0]   r_frame;
    logic [31:0]               r_fill_addr;
    logic [31:0]               r_wb_addr;
    logic [31:0]               r_word;
    logic [31:0]               r_wb_buf [BLOCK_SIZE];

    logic [N_BLOCK_BITS-1:0]   w_start;
    logic [N_BLOCK_BITS-1:0]   w_cnt_inc;
    logic [31:0]               w_cnt_off;
    logic                      w_fill_last;

`ifdef L1_FILL_CRITICAL_WORD_FIRST_EN
    assign w_start = req_word;
`else
    // req_word is accepted on the port but has no effect in this build
    assign w_start = req_word & '0;
`endif

    assign w_cnt_inc   = (r_cnt == LP_LAST) ? '0 : r_cnt + N_BLOCK_BITS'(1);
    assign w_cnt_off   = {{(30 - N_BLOCK_BITS){1'b0}}, r_cnt, 2'b00};
    // The fill always moves exactly BLOCK_SIZE words: it ends when the counter is back at its start.
    assign w_fill_last = (w_cnt_inc == r_start);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge nRST) begin : p_state_reg
        if (nRST) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin : p_next_state
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:     if (req_valid)  w_next_state = req_wb ? S_WB_RD : S_FILL_REQ;
            S_WB_RD:    if (!sram_busy) w_next_state = S_WB_REQ;
            S_WB_REQ:   if (!bus_busy && (r_cnt == LP_LAST)) w_next_state = S_FILL_REQ;
            S_FILL_REQ: if (!bus_busy)  w_next_state = S_FILL_WR;
            S_FILL_WR:  if (!sram_busy) w_next_state = w_fill_last ? S_DONE : S_FILL_REQ;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // NOTE: the wb buffer is reset because its cleared value is part of the defined reset state.
    always_ff @(posedge CLK or posedge nRST) begin : p_datapath
        if (nRST) begin
            r_cnt       <= '0;
            r_start     <= '0;
            r_set       <= '0;
            r_frame     <= '0;
            r_fill_addr <= '0;
            r_wb_addr   <= '0;
            r_word      <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) r_wb_buf[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_set       <= req_set;
                    r_frame     <= req_frame;
                    r_fill_addr <= req_fill_addr;
                    r_wb_addr   <= req_wb_addr;
                    r_start     <= w_start;
                    r_cnt       <= w_start;
                end
                S_WB_RD: if (!sram_busy) begin
                    for (int i = 0; i < BLOCK_SIZE; i++) r_wb_buf[i] <= sram_rdata[32*i +: 32];
                    r_cnt <= '0;
                end
                S_WB_REQ:   if (!bus_busy)  r_cnt  <= (r_cnt == LP_LAST) ? r_start : w_cnt_inc;
                S_FILL_REQ: if (!bus_busy)  r_word <= bus_rdata;
                S_FILL_WR:  if (!sram_busy) r_cnt  <= w_cnt_inc;
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first so the decode cannot infer a latch.
    always_comb begin : p_outputs
        req_ready  = 1'b0;
        done       = 1'b0;
        bus_addr   = '0;
        bus_ren    = 1'b0;
        bus_wen    = 1'b0;
        bus_wdata  = '0;
        sram_set   = '0;
        sram_frame = '0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_oe    = 1'b0;
        sram_word  = '0;
        sram_wdata = '0;
        if (r_state != S_IDLE) begin
            sram_set   = r_set;
            sram_frame = r_frame;
        end
        case (r_state)
            S_IDLE: req_ready = 1'b1;
            S_WB_RD: begin
                sram_cs = 1'b1;
                sram_oe = 1'b1;
            end
            S_WB_REQ: begin
                bus_wen   = 1'b1;
                bus_addr  = r_wb_addr + w_cnt_off;
                bus_wdata = r_wb_buf[r_cnt];
            end
            S_FILL_REQ: begin
                bus_ren  = 1'b1;
                bus_addr = r_fill_addr + w_cnt_off;
            end
            S_FILL_WR: begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_word  = r_cnt;
                sram_wdata = r_word;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1_block_fill_ctrl.sv
// Bench for l1_block_fill_ctrl: bus/SRAM models, transaction scoreboard and request vector table.
// Built with L1_FILL_CRITICAL_WORD_FIRST_EN it runs with BLOCK_SIZE=4 and critical-word-first order.
`timescale 1ns/1ps
module tb_l1_block_fill_ctrl;

`ifdef L1_FILL_CRITICAL_WORD_FIRST_EN
    localparam int BS  = 4;
    localparam int NB  = 2;
    localparam bit CWF = 1'b1;
`else
    localparam int BS  = 2;
    localparam int NB  = 1;
    localparam bit CWF = 1'b0;
`endif
    localparam int NS = 6;
    localparam int NF = 1;

    logic              CLK = 1'b0;
    logic              nRST = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wb = 1'b0;
    logic [NS-1:0]     req_set = '0;
    logic [NF-1:0]     req_frame = '0;
    logic [NB-1:0]     req_word = '0;
    logic [31:0]       req_fill_addr = '0;
    logic [31:0]       req_wb_addr = '0;
    logic              done;
    logic [31:0]       bus_addr;
    logic              bus_ren;
    logic              bus_wen;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_busy;
    logic [NS-1:0]     sram_set;
    logic [NF-1:0]     sram_frame;
    logic              sram_cs;
    logic              sram_we;
    logic              sram_oe;
    logic [NB-1:0]     sram_word;
    logic [31:0]       sram_wdata;
    logic [BS*32-1:0]  sram_rdata;
    logic              sram_busy;

    l1_block_fill_ctrl #(
        .N_SET_BITS(NS), .N_FRAME_BITS(NF), .BLOCK_SIZE(BS), .N_BLOCK_BITS(NB)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_set(req_set), .req_frame(req_frame), .req_word(req_word),
        .req_fill_addr(req_fill_addr), .req_wb_addr(req_wb_addr), .done(done),
        .bus_addr(bus_addr), .bus_ren(bus_ren), .bus_wen(bus_wen),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_busy(bus_busy),
        .sram_set(sram_set), .sram_frame(sram_frame), .sram_cs(sram_cs),
        .sram_we(sram_we), .sram_oe(sram_oe), .sram_word(sram_word),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_busy(sram_busy)
    );

    always #5 CLK = ~CLK;

    // Memory data is a fixed function of the address so expectations come from the address alone.
    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return 32'hA0 + {26'h0, a[7:2]};
    endfunction

    // Bus: each transfer is busy for bus_waits cycles; SRAM: busy the first cycle, done the second.
    int          bus_waits = 0;
    int          bus_wait_cnt = 0;
    logic        sram_phase = 1'b0;
    logic [31:0] wb_words [BS];

    always @(posedge CLK) begin
        if ((bus_ren || bus_wen) && bus_busy) bus_wait_cnt <= bus_wait_cnt + 1;
        else                                  bus_wait_cnt <= 0;
        sram_phase <= sram_cs && !sram_phase;
    end

    assign bus_busy  = (bus_ren || bus_wen) && (bus_wait_cnt < bus_waits);
    assign bus_rdata = (bus_ren && !bus_busy) ? rd_data(bus_addr) : 32'hDEAD_BEEF;
    assign sram_busy = sram_cs && !sram_phase;

    always_comb begin
        sram_rdata = '0;
        for (int i = 0; i < BS; i++) sram_rdata[32*i +: 32] = sram_busy ? 32'hFFFF_FFFF : wb_words[i];
    end

    typedef enum logic [1:0] {K_SRD, K_BW, K_BR, K_SW} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          wb;
        logic [NS-1:0] set;
        logic [NF-1:0] frame;
        logic [NB-1:0] word;
        logic [31:0] fill;
        logic [31:0] wba;
        logic [31:0] seed;
        int          waits;
        int          exp_done;
    } vec_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [NS-1:0] cur_set = '0;
    logic [NF-1:0] cur_frame = '0;
    logic        prev_busy = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [1:0]  prev_strb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic pop_cmp(input kind_e kind, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("txn_expected", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("txn_kind", 32'(kind), 32'(e.kind));
            check("txn_addr", addr, e.addr);
            check("txn_data", data, e.data);
        end
    endtask

    // Monitor: samples on the falling edge, scores every completed bus/SRAM transfer.
    always @(negedge CLK) begin
        if (nRST === 1'b0) begin
            check("bus_rw_excl", {31'b0, bus_ren && bus_wen}, 32'd0);
            check("sram_we_oe_excl", {31'b0, sram_we && sram_oe}, 32'd0);
            if (prev_busy) begin
                check("bus_addr_stable", bus_addr, prev_addr);
                check("bus_strb_stable", {30'b0, bus_ren, bus_wen}, {30'b0, prev_strb});
            end
            prev_busy = (bus_ren || bus_wen) && bus_busy;
            prev_addr = bus_addr;
            prev_strb = {bus_ren, bus_wen};
            if ((bus_ren || bus_wen) && !bus_busy)
                pop_cmp(bus_wen ? K_BW : K_BR, bus_addr, bus_wen ? bus_wdata : 32'd0);
            if (sram_cs && !sram_busy) begin
                pop_cmp(sram_we ? K_SW : K_SRD, sram_we ? 32'(sram_word) : 32'd0,
                        sram_we ? sram_wdata : 32'd0);
                check("sram_set", 32'(sram_set), 32'(cur_set));
                check("sram_frame", 32'(sram_frame), 32'(cur_frame));
            end
        end else begin
            prev_busy = 1'b0;
        end
    end

    function automatic int lat(input bit wb, input int waits);
        return 1 + BS * (3 + waits) + (wb ? 2 + BS * (1 + waits) : 0);
    endfunction

    task automatic push_exp(input vec_t v);
        logic [31:0] a;
        int          w;
        int          start;
        start = CWF ? int'(v.word) : 0;
        if (v.wb) begin
            exp_q.push_back('{K_SRD, 32'd0, 32'd0});
            for (int i = 0; i < BS; i++)
                exp_q.push_back('{K_BW, v.wba + 32'(4 * i), v.seed + 32'(i)});
        end
        for (int j = 0; j < BS; j++) begin
            w = (start + j) % BS;
            a = v.fill + 32'(4 * w);
            exp_q.push_back('{K_BR, a, 32'd0});
            exp_q.push_back('{K_SW, 32'(w), rd_data(a)});
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_valid     = 1'b1;
        req_wb        = v.wb;
        req_set       = v.set;
        req_frame     = v.frame;
        req_word      = v.word;
        req_fill_addr = v.fill;
        req_wb_addr   = v.wba;
    endtask

    task automatic run_req(input vec_t v);
        int got;
        cur_set   = v.set;
        cur_frame = v.frame;
        bus_waits = v.waits;
        for (int i = 0; i < BS; i++) wb_words[i] = v.seed + 32'(i);
        push_exp(v);
        @(negedge CLK);
        check("ready_before_req", {31'b0, req_ready}, 32'd1);
        drive_req(v);
        got = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge CLK);
            if (k == 1) req_valid = 1'b0;
            if (done) begin
                got = k;
                break;
            end
        end
        check("done_cycle", 32'(got), 32'(v.exp_done));
        @(negedge CLK);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("ready_after_done", {31'b0, req_ready}, 32'd1);
        check("txns_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    vec_t vecs[4];

    initial begin
        vec_t b2b_a;
        vec_t b2b_b;
        vec_t ab;
        int   k_done;
        int   got;
        bit   seen;

        vecs[0] = '{1'b0, NS'(5),  NF'(1), NB'(1), 32'h0000_1000, 32'h0,         32'h0,  0, 0};
        vecs[1] = '{1'b1, NS'(42), NF'(0), NB'(0), 32'h0000_3000, 32'h0000_2000, 32'hB0, 0, 0};
        vecs[2] = '{1'b0, NS'(63), NF'(1), NB'(2), 32'h0000_4000, 32'h0,         32'h0,  3, 0};
        vecs[3] = '{1'b1, NS'(0),  NF'(1), NB'(3), 32'hFFFF_FFFC, 32'h0000_8000, 32'hC0, 2, 0};
        for (int i = 0; i < 4; i++) vecs[i].exp_done = lat(vecs[i].wb, vecs[i].waits);
        for (int i = 0; i < BS; i++) wb_words[i] = '0;

        // Reset held two cycles, then ten idle cycles with nothing moving.
        @(negedge CLK);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_strobes", {26'b0, bus_ren, bus_wen, sram_cs, sram_we, sram_oe, done}, 32'd0);
        check("rst_sram_set", 32'(sram_set), 32'd0);
        @(negedge CLK);
        nRST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("idle_ready", {31'b0, req_ready}, 32'd1);
            check("idle_strobes", {26'b0, bus_ren, bus_wen, sram_cs, sram_we, sram_oe, done}, 32'd0);
        end

        for (int i = 0; i < 4; i++) run_req(vecs[i]);

        // Back-to-back: valid held high; the second request is taken only after done.
        b2b_a = '{1'b0, NS'(3), NF'(0), NB'(0), 32'h0000_5000, 32'h0, 32'h0, 0, 0};
        b2b_b = b2b_a;
        b2b_b.fill = 32'h0000_6000;
        cur_set = b2b_a.set; cur_frame = b2b_a.frame; bus_waits = 0;
        push_exp(b2b_a);
        push_exp(b2b_b);
        @(negedge CLK);
        drive_req(b2b_a);
        k_done = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge CLK);
            if (k == 1) req_fill_addr = b2b_b.fill;
            if (done) begin
                k_done = k;
                break;
            end
        end
        check("b2b_first_done", 32'(k_done), 32'(lat(1'b0, 0)));
        check("b2b_ready_in_done", {31'b0, req_ready}, 32'd0);
        @(negedge CLK);
        check("b2b_ready_after", {31'b0, req_ready}, 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        check("b2b_second_ren", {31'b0, bus_ren}, 32'd1);
        check("b2b_second_addr", bus_addr, b2b_b.fill);
        got = -1;
        for (int k = 2; k <= 400; k++) begin
            @(negedge CLK);
            if (done) begin
                got = k;
                break;
            end
        end
        check("b2b_second_done", 32'(got), 32'(lat(1'b0, 0)));
        @(negedge CLK);
        check("b2b_txns_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Reset asserted while in FILL_WR: strobes drop at once and no done follows.
        ab = '{1'b0, NS'(7), NF'(1), NB'(0), 32'h0000_7000, 32'h0, 32'h0, 0, 0};
        cur_set = ab.set; cur_frame = ab.frame; bus_waits = 0;
        push_exp(ab);
        @(negedge CLK);
        drive_req(ab);
        seen = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            if (k == 1) req_valid = 1'b0;
            if (sram_we) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_reached_fill_wr", {31'b0, seen}, 32'd1);
        #1 nRST = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        check("abort_strobes", {26'b0, bus_ren, bus_wen, sram_cs, sram_we, sram_oe, done}, 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        nRST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("abort_quiet", {26'b0, bus_ren, bus_wen, sram_cs, sram_we, sram_oe, done}, 32'd0);
        end

        run_req(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l1_block_fill_ctrl.md
Name: l1_block_fill_ctrl

Overview:
- Line-fill/writeback sequencer sitting directly upstream of the L1 data SRAM wrapper.
- On a miss request it optionally evicts a dirty block: reads the whole block from the SRAM, then writes it word-by-word to the memory-side generic bus.
- It then fetches the new block word-by-word over the bus and writes each word into the SRAM.
- It obeys the SRAM's two-cycle handshake (an access completes in the cycle the SRAM busy reads 0).

Parameters:
- N_SET_BITS, 6, width of SRAM set index
- N_FRAME_BITS, 1, width of way/frame index
- BLOCK_SIZE, 2, 32-bit words per block (power of 2, 1..8)
- N_BLOCK_BITS, 1, $clog2(BLOCK_SIZE), minimum 1

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-high; clock CLK
- req_valid  in  1  miss request valid
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_wb  in  1  evict (write back) the victim block before the fill
- req_set  in  N_SET_BITS  target set
- req_frame  in  N_FRAME_BITS  target frame
- req_word  in  N_BLOCK_BITS  critical word index (used only with the optional feature)
- req_fill_addr  in  32  block-aligned byte address to fetch
- req_wb_addr  in  32  block-aligned byte address of the victim
- done  out  1  one-cycle pulse when the sequence completes
- bus_addr  out  32  memory bus address
- bus_ren  out  1  memory bus read
- bus_wen  out  1  memory bus write
- bus_wdata  out  32  memory bus write data
- bus_rdata  in  32  memory bus read data
- bus_busy  in  1  low in the cycle the bus transfer completes
- sram_set  out  N_SET_BITS  to the SRAM wrapper's set_bits
- sram_frame  out  N_FRAME_BITS  to frame_bits
- sram_cs  out  1  chip_select
- sram_we  out  1  write_enable
- sram_oe  out  1  output_enable
- sram_word  out  N_BLOCK_BITS  word_num
- sram_wdata  out  32  input_data
- sram_rdata  in  BLOCK_SIZE*32  output_data (word i at bits [32i+31:32i])
- sram_busy  in  1  SRAM busy

Behaviour:
- Reset: state IDLE, counters 0, wb buffer 0.
  - All outputs 0 except req_ready=1.
  - Reset mid-sequence aborts immediately: no done pulse, bus and SRAM strobes drop the same cycle.
- States: IDLE, WB_RD, WB_REQ, FILL_REQ, FILL_WR, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch set/frame/addresses/word; next state is WB_RD if req_wb, else FILL_REQ.
  - word counter = 0 (or req_word with the optional feature).
- WB_RD:
  - sram_cs=sram_oe=1 held until a cycle with sram_busy=0.
  - In that cycle, capture sram_rdata into the BLOCK_SIZE-word wb buffer, then go to WB_REQ with counter 0.
- WB_REQ:
  - bus_wen=1, bus_addr=wb_addr+4*cnt, bus_wdata=buffer[cnt], held until bus_busy=0.
  - On completion: if cnt==BLOCK_SIZE-1, go to FILL_REQ (cnt reset); else cnt+1.
- FILL_REQ:
  - bus_ren=1, bus_addr=fill_addr+4*cnt, held until bus_busy=0.
  - Capture bus_rdata into a word register, then go to FILL_WR.
- FILL_WR:
  - sram_cs=sram_we=1, sram_word=cnt, sram_wdata=captured word, held until sram_busy=0.
  - Then go to DONE if this was the last word, else to FILL_REQ with cnt advanced.
- DONE: done=1 for one cycle, then IDLE.
- sram_set/sram_frame hold the latched values in every non-IDLE state; they are 0 in IDLE.
- At most one of bus_ren/bus_wen is high; sram_we and sram_oe are never high together.
- Address arithmetic is modulo 2^32; the low bits of latched addresses are not checked.
- Counter wraps modulo BLOCK_SIZE. The word count is always exactly BLOCK_SIZE.
- req_valid while not IDLE is ignored (req_ready=0). A request arriving in the DONE cycle is not accepted.
- Latency, zero-wait bus and BLOCK_SIZE=2:
  - Fill only: accept edge, then 3 cycles per word; done in cycle 7 after acceptance.
  - Writeback: adds 2 (WB_RD) plus 1 per word (2 for BLOCK_SIZE=2), i.e. done in cycle 11.

Optional Feature:
- Macro: L1_FILL_CRITICAL_WORD_FIRST_EN.
- Defined: the fill counter starts at req_word and wraps modulo BLOCK_SIZE.
  - Termination is after BLOCK_SIZE words, i.e. when the next counter equals req_word.
  - Bus address and sram_word follow the counter.
- Undefined: req_word is ignored and the fill starts at word 0.
- Writeback order is always 0..BLOCK_SIZE-1 in both cases.

Test Plan:
- Reset then idle:
  - Stimulus: nRST high 2 cycles, then low.
  - Required: req_ready=1; all strobes and done 0; no bus or SRAM activity for 10 cycles.
- Fill only, zero-wait bus:
  - Stimulus: set=5, frame=1, fill_addr=0x1000, bus_rdata 0xA0/0xA1.
  - Required: bus reads at 0x1000 then 0x1004; SRAM writes word0=0xA0, word1=0xA1 to set 5/frame 1; done in cycle 7.
- Writeback+fill:
  - Stimulus: sram_rdata={0xB1,0xB0}, wb_addr=0x2000.
  - Required: bus writes 0x2000<-0xB0 then 0x2004<-0xB1 before any bus read; fill then proceeds; done in cycle 11.
- Bus wait states:
  - Stimulus: bus_busy held 1 for 3 cycles on each word.
  - Required: addr/ren stable while busy; each word captured only in the busy=0 cycle; done delayed by 6 cycles.
- Back-to-back requests and reset abort:
  - Stimulus: second req_valid held during a fill.
  - Required: second request accepted only in the cycle after done.
  - Stimulus: nRST asserted in FILL_WR.
  - Required: all strobes 0 next cycle; no done pulse.
- With L1_FILL_CRITICAL_WORD_FIRST_EN, BLOCK_SIZE=4, req_word=2:
  - Required: bus read order 0x..08, 0x..0C, 0x..00, 0x..04; sram_word order 2,3,0,1.
